// File: rtl/vproc_mem_arbiter.sv
// rtl/vproc_mem_arbiter.sv - shares one memory port among REQ_CNT requesters, routes in-order responses back
// Define VPROC_MEM_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module vproc_mem_arbiter #(
  parameter int REQ_CNT         = 3,
  parameter int MAX_OUTSTANDING = 4,
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [REQ_CNT-1:0]          req_i,
  input  logic [REQ_CNT*ADDR_W-1:0]   addr_i,
  input  logic [REQ_CNT-1:0]          we_i,
  input  logic [REQ_CNT*DATA_W/8-1:0] be_i,
  input  logic [REQ_CNT*DATA_W-1:0]   wdata_i,
  output logic [REQ_CNT-1:0]          gnt_o,
  output logic [REQ_CNT-1:0]          rvalid_o,
  output logic                        err_o,
  output logic [DATA_W-1:0]           rdata_o,
  output logic                        mem_req_o,
  output logic [ADDR_W-1:0]           mem_addr_o,
  output logic                        mem_we_o,
  output logic [DATA_W/8-1:0]         mem_be_o,
  output logic [DATA_W-1:0]           mem_wdata_o,
  input  logic                        mem_rvalid_i,
  input  logic                        mem_err_i,
  input  logic [DATA_W-1:0]           mem_rdata_i,
  output logic                        spurious_o
);
  localparam int BE_W  = DATA_W / 8;
  localparam int IDX_W = (REQ_CNT > 1) ? $clog2(REQ_CNT) : 1;
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [IDX_W-1:0] id_fifo [MAX_OUTSTANDING];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic [IDX_W-1:0] start;
  logic [IDX_W-1:0] cand;
  logic [IDX_W-1:0] winner;
  logic             found;
  logic             can_issue;
  logic             issue;
  logic             pop;
  logic             spurious;

`ifdef VPROC_MEM_ARB_FIXED_PRIO_EN
  assign start = '0;
`else
  logic [IDX_W-1:0] rr_ptr;
  assign start = rr_ptr;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr <= '0;
    end else if (issue) begin
      rr_ptr <= (winner == IDX_W'(REQ_CNT - 1)) ? '0 : winner + IDX_W'(1);
    end
  end
`endif

  // First requester at or above the start index, wrapping modulo REQ_CNT.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int k = 0; k < REQ_CNT; k++) begin
      cand = IDX_W'((int'(start) + k) % REQ_CNT);
      if (!found && req_i[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // A same-cycle response frees a slot, so a full FIFO can still accept.
  assign can_issue = (count < CNT_W'(MAX_OUTSTANDING)) | mem_rvalid_i;
  assign issue     = found & can_issue & ~rst_i;
  assign pop       = mem_rvalid_i & (count != '0) & ~rst_i;
  assign mem_req_o = issue;

  always_comb begin
    gnt_o       = '0;
    rvalid_o    = '0;
    mem_addr_o  = '0;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_wdata_o = '0;
    for (int k = 0; k < REQ_CNT; k++) begin
      if (issue && winner == IDX_W'(k)) begin
        gnt_o[k]    = 1'b1;
        mem_addr_o  = addr_i[k*ADDR_W +: ADDR_W];
        mem_we_o    = we_i[k];
        mem_be_o    = be_i[k*BE_W +: BE_W];
        mem_wdata_o = wdata_i[k*DATA_W +: DATA_W];
      end
      if (pop && id_fifo[head] == IDX_W'(k)) begin
        rvalid_o[k] = 1'b1;
      end
    end
  end

  assign err_o      = pop & mem_err_i;
  assign rdata_o    = mem_rdata_i;
  assign spurious_o = spurious;

  always_ff @(posedge clk_i) begin
    if (issue) begin
      id_fifo[tail] <= winner;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      spurious <= 1'b0;
    end else begin
      if (pop) begin
        head <= (head == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : head + PTR_W'(1);
      end
      if (issue) begin
        tail <= (tail == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : tail + PTR_W'(1);
      end
      count <= count + CNT_W'(issue) - CNT_W'(pop);
      // Responses with nothing outstanding (including ones in flight across a reset) are dropped.
      if (mem_rvalid_i && count == '0) begin
        spurious <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vproc_mem_arbiter.sv
// tb/tb_vproc_mem_arbiter.sv - scoreboard bench for vproc_mem_arbiter
// Directed stimulus with a fixed-latency in-order memory model; a monitor checks routed responses.
module tb_vproc_mem_arbiter;
`ifdef VPROC_MEM_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req_i;
  logic [95:0] addr_i;
  logic [2:0]  we_i;
  logic [11:0] be_i;
  logic [95:0] wdata_i;
  logic [2:0]  gnt_o;
  logic [2:0]  rvalid_o;
  logic        err_o;
  logic [31:0] rdata_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic        mem_rvalid_i = 1'b0;
  logic        mem_err_i = 1'b0;
  logic [31:0] mem_rdata_i = 32'h0;
  logic        spurious_o;

  always #5 clk = ~clk;

  vproc_mem_arbiter dut (
    .clk_i(clk), .rst_i(rst), .req_i(req_i), .addr_i(addr_i), .we_i(we_i), .be_i(be_i),
    .wdata_i(wdata_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o), .err_o(err_o), .rdata_o(rdata_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_wdata_o(mem_wdata_o), .mem_rvalid_i(mem_rvalid_i), .mem_err_i(mem_err_i),
    .mem_rdata_i(mem_rdata_i), .spurious_o(spurious_o)
  );

  typedef struct { int due; logic err; logic [31:0] rdata; } mresp_t;
  typedef struct { logic [2:0] rv; logic err; logic [31:0] rdata; } exp_t;

  mresp_t mem_q[$];
  exp_t   exp_q[$];
  exp_t   mon_e;
  int     cyc = 0;
  int     lat = 1;
  int     checks = 0;
  int     errors = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  // Memory model: read data is addr ^ DEADBFEF, error when addr[31] is set.
  always @(posedge clk) begin
    #1;
    cyc++;
    mem_rvalid_i = 1'b0;
    mem_err_i    = 1'b0;
    mem_rdata_i  = 32'h0;
    if (mem_q.size() > 0 && mem_q[0].due == cyc) begin
      mem_rvalid_i = 1'b1;
      mem_err_i    = mem_q[0].err;
      mem_rdata_i  = mem_q[0].rdata;
      void'(mem_q.pop_front());
    end
  end

  always @(negedge clk) begin
    if (mem_req_o) mem_q.push_back('{due: cyc + lat, err: mem_addr_o[31], rdata: mem_addr_o ^ 32'hDEADBFEF});
  end

  always @(negedge clk) begin
    if (rvalid_o != 3'b000) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rvalid: got %b expected none", rvalid_o);
      end else begin
        mon_e = exp_q.pop_front();
        check("rvalid", {29'h0, rvalid_o}, {29'h0, mon_e.rv});
        check("err", {31'h0, err_o}, {31'h0, mon_e.err});
        check("rdata", rdata_o, mon_e.rdata);
      end
    end else if (err_o !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL err_idle: got %b expected 0", err_o);
    end
  end

  function automatic exp_t resp_of(input logic [2:0] g);
    exp_t e;
    e.rv = g; e.err = 1'b0; e.rdata = 32'h0;
    for (int i = 0; i < 3; i++) begin
      if (g[i]) begin
        e.err   = addr_i[i*32+31];
        e.rdata = addr_i[i*32 +: 32] ^ 32'hDEADBFEF;
      end
    end
    return e;
  endfunction

  task automatic cyc_chk(input logic [2:0] req, input logic [2:0] eg, input string nm);
    @(posedge clk); #1;
    req_i = req;
    @(negedge clk);
    check(nm, {29'h0, gnt_o}, {29'h0, eg});
    if (eg != 3'b000) exp_q.push_back(resp_of(eg));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      req_i = 3'b000;
    end
  endtask

  logic [2:0] t2_gnt [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
  logic [2:0] t3_gnt [8] = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b000, 3'b000, 3'b001, 3'b001};
  logic [2:0] t6_gnt [3] = '{3'b010, 3'b100, 3'b001};

  initial begin
    rst = 1'b1; req_i = 3'b111; we_i = 3'b000; be_i = 12'hFFF; wdata_i = '0;
    addr_i = {32'h30, 32'h20, 32'h10};
    repeat (2) begin
      @(negedge clk);
      check("rst_gnt", {29'h0, gnt_o}, 32'h0);
      check("rst_mem_req", {31'h0, mem_req_o}, 32'h0);
    end
    check("rst_spurious", {31'h0, spurious_o}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0; req_i = 3'b000;

    // Round-robin with all requesting, latency 1
    lat = 1;
    for (int i = 0; i < 6; i++) cyc_chk(3'b111, FIXED ? 3'b001 : t2_gnt[i], "t2_gnt");
    idle(3);

    // Single read by requester 1
    addr_i[32 +: 32] = 32'h100;
    @(posedge clk); #1;
    req_i = 3'b010;
    @(negedge clk);
    check("t1_gnt", {29'h0, gnt_o}, 32'h2);
    check("t1_addr", mem_addr_o, 32'h100);
    check("t1_we", {31'h0, mem_we_o}, 32'h0);
    exp_q.push_back('{rv: 3'b010, err: 1'b0, rdata: 32'hDEADBEEF});
    idle(3);

    // Stall at full FIFO, latency 6
    lat = 6;
    addr_i[0 +: 32] = 32'h40;
    for (int i = 0; i < 8; i++) cyc_chk(3'b001, t3_gnt[i], "t3_gnt");
    idle(10);

    // Write with downstream error, byte-enable/wdata mux
    lat = 2;
    addr_i[64 +: 32] = 32'h8000_0000; we_i = 3'b100; be_i[8 +: 4] = 4'hA; wdata_i[64 +: 32] = 32'h12345678;
    @(posedge clk); #1;
    req_i = 3'b100;
    @(negedge clk);
    check("t4_gnt", {29'h0, gnt_o}, 32'h4);
    check("t4_addr", mem_addr_o, 32'h8000_0000);
    check("t4_we", {31'h0, mem_we_o}, 32'h1);
    check("t4_be", {28'h0, mem_be_o}, 32'hA);
    check("t4_wdata", mem_wdata_o, 32'h12345678);
    exp_q.push_back('{rv: 3'b100, err: 1'b1, rdata: 32'h5EADBFEF});
    idle(4);
    we_i = 3'b000; addr_i[64 +: 32] = 32'h30;

    // Spurious response coinciding with a grant
    lat = 1;
    @(negedge clk);
    mem_q.push_back('{due: cyc + 1, err: 1'b0, rdata: 32'h0BADF00D});
    @(posedge clk); #1;
    req_i = 3'b001;
    @(negedge clk);
    check("t5_rvalid", {29'h0, rvalid_o}, 32'h0);
    check("t5_gnt", {29'h0, gnt_o}, 32'h1);
    check("t5_spur_pre", {31'h0, spurious_o}, 32'h0);
    exp_q.push_back('{rv: 3'b001, err: 1'b0, rdata: 32'hDEADBFAF});
    idle(1);
    @(negedge clk);
    check("t5_spur_set", {31'h0, spurious_o}, 32'h1);
    idle(3);
    @(negedge clk);
    check("t5_spur_hold", {31'h0, spurious_o}, 32'h1);

    // Reset with 3 outstanding; in-flight responses become spurious
    lat = 6;
    for (int i = 0; i < 3; i++) cyc_chk(3'b111, FIXED ? 3'b001 : t6_gnt[i], "t6_gnt");
    @(posedge clk); #1;
    req_i = 3'b000; rst = 1'b1;
    @(negedge clk);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("t6_spur_clr", {31'h0, spurious_o}, 32'h0);
    idle(4);
    @(negedge clk);
    check("t6_spur_set", {31'h0, spurious_o}, 32'h1);
    lat = 1;
    cyc_chk(3'b111, 3'b001, "t6_rr_reset");
    idle(4);
    @(negedge clk);
    check("drain", exp_q.size(), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
